mem_stage_access_ctrl: RTL and testbench
========================================

# mem_stage_access_ctrl

MEM-stage access controller on the consumer side of the EX/MEM pipeline register. Takes the registered memory control bits, address and store data, runs one request/response transaction per memory instruction against a variable-latency data memory, and asserts a pipeline stall until the access completes. Presents load data to the MEM/WB register in a defined completion cycle and flags memories that never respond.

## Interface
Parameters:
- TIMEOUT, 15: max WAIT cycles before abort; range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead  in  1  load request from the EX/MEM register.
- MemWrite  in  1  store request from the EX/MEM register.
- Addr  in  16  memory address; the ALU result from EX/MEM.
- WriteData  in  16  store data from EX/MEM.
- mem_en  out  1  one-cycle request strobe to data memory.
- mem_wr  out  1  1 = write, 0 = read; valid with mem_en.
- mem_addr  out  16  registered request address.
- mem_wdata  out  16  registered store data.
- mem_rdata  in  16  memory read data; sampled only when mem_valid = 1.
- mem_valid  in  1  one-cycle completion pulse from memory.
- Stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM when 1.
- ReadData  out  16  load result to MEM/WB; held between loads.
- Done  out  1  1 in the completion cycle of every access.
- Err  out  1  sticky timeout flag; cleared only by rst.

## Operation
- States: IDLE, WAIT, DONE.
- Request: req = MemRead | MemWrite. If both are 1, the access is a write (MemWrite has priority).
- IDLE, req = 0:
  - Stall = 0, mem_en = 0.
  - ReadData holds its value.
  - Stay in IDLE.
- IDLE, req = 1:
  - Stall = 1.
  - At the clock edge: latch Addr into mem_addr, WriteData into mem_wdata, and MemWrite into mem_wr; clear the timeout counter; go to WAIT.
- WAIT:
  - mem_en = 1 in the first WAIT cycle only.
  - Stall = 1 in every WAIT cycle.
  - Counter increments each cycle that mem_valid = 0.
  - mem_valid = 1: on a read, capture mem_rdata into ReadData; on a write, leave ReadData unchanged. Go to DONE.
  - Counter reaches TIMEOUT with mem_valid = 0: set Err. On a read, load ReadData = 16'h0000. Go to DONE.
  - mem_valid and the timeout in the same cycle: mem_valid wins and Err is not set.
- DONE:
  - Stall = 0, Done = 1.
  - MEM/WB captures ReadData at this edge, and EX/MEM advances.
  - Always go to IDLE; req is ignored in DONE, so the same instruction is never re-issued.
- mem_valid is ignored in IDLE and DONE; late or stray responses are discarded.
- The non-memory control bits (MemtoReg, PCS) are not handled here; they pass EX/MEM → MEM/WB unchanged.

## Timing
- Reset values:
  - state = IDLE.
  - Stall = 0, mem_en = 0, mem_wr = 0, Done = 0, Err = 0.
  - mem_addr = 0, mem_wdata = 0, ReadData = 0.
  - Counter = 0.
- Reset mid-access (WAIT or DONE): next cycle is IDLE with all outputs at their reset values. An in-flight memory response is dropped.
- Request strobe: mem_en rises one cycle after the request is seen in IDLE.
- Stall cycles per access: for a memory response k cycles after mem_en (k ≥ 0 within WAIT), Stall is high for 2 + k cycles, and Done follows immediately.
- Minimum cost: 3 cycles per memory instruction. A back-to-back memory op is issued from IDLE in the cycle after DONE.
- Timeout case: Stall is high for 1 + TIMEOUT cycles, then DONE.
- Stall is a registered-state decode plus req in IDLE. No path exists from mem_valid to Stall.

## Structure
- Shared package cpu_pkg:
  - State encoding: IDLE = 2'b00, WAIT = 2'b01, DONE = 2'b10.
  - Width constants: WORD_W = 16, and the counter width CNT_W = 8.
- Reuse the existing dff_16 for the mem_addr, mem_wdata and ReadData registers, and dff for state bits and Err.
- One new sub-module, dmem_timeout_cnt: an 8-bit counter with sync clear, enable, and a terminal-count output compared against TIMEOUT.

## Test plan
- Load, 0-cycle memory: MemRead = 1, Addr = 16'h0040, mem_valid in the first WAIT cycle with mem_rdata = 16'hBEEF.
  - Required: mem_en for exactly 1 cycle with mem_wr = 0 and mem_addr = 16'h0040.
  - Stall high for 2 cycles, then Done; ReadData = 16'hBEEF.
- Store, 3-cycle memory: MemWrite = 1, Addr = 16'h0100, WriteData = 16'h1234, mem_valid 3 cycles after mem_en.
  - Required: mem_wr = 1, mem_wdata = 16'h1234, Stall high for 5 cycles.
  - ReadData unchanged from its previous value.
- Back-to-back: a load followed immediately by a store.
  - Required: second mem_en is 3 cycles after the first (0-cycle memory).
  - Only one mem_en per instruction; none in a DONE cycle.
- Timeout: TIMEOUT = 4, load, mem_valid never asserted.
  - Required: Stall high for 5 cycles, then Done = 1 with Err = 1 and ReadData = 0.
  - Err still 1 after a later successful load; cleared by rst.
- Reset in WAIT, then a stray mem_valid in the next cycle.
  - Required: all outputs at reset values, state IDLE.
  - ReadData not updated by the stray response; no Done.
- Simultaneous MemRead = MemWrite = 1, plus a mem_valid pulse in IDLE with no request.
  - Required: access issued with mem_wr = 1; the stray mem_valid in IDLE has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MEM-stage FSM encoding and datapath widths.
package cpu_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 8;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/dff.sv
// Single-bit register with synchronous active-high reset and load enable.
module dff (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_16.sv
// Word-wide register with synchronous active-high reset and load enable.
module dff_16
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dmem_timeout_cnt.sv
// Wait-cycle counter for data-memory accesses; tc marks the last allowed WAIT cycle.
module dmem_timeout_cnt
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    // tc fires when this cycle's increment would bring the count to TIMEOUT
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage access controller: one request/response per memory instruction,
// stalling the front of the pipeline until the data memory completes or times out.
module mem_stage_access_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [WORD_W-1:0] Addr,
    input  logic [WORD_W-1:0] WriteData,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              Stall,
    output logic [WORD_W-1:0] ReadData,
    output logic              Done,
    output logic              Err
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              req;
    logic              is_idle;
    logic              is_wait;
    logic              is_done;
    logic              issue;
    logic              finish_ok;
    logic              abort;
    logic              rd_load;
    logic [WORD_W-1:0] rd_next;
    logic [CNT_W-1:0]  count;
    logic              tc;

    assign req     = MemRead | MemWrite;
    assign is_idle = (state == S_IDLE);
    assign is_wait = (state == S_WAIT);
    assign is_done = (state == S_DONE);

    assign issue     = is_idle & req;
    assign finish_ok = is_wait & mem_valid;
    // a response in the final WAIT cycle takes precedence over the timeout
    assign abort     = is_wait & ~mem_valid & tc;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = req ? S_WAIT : S_IDLE;
            S_WAIT:  state_nxt = (mem_valid || tc) ? S_DONE : S_WAIT;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    dff u_state0 (.clk(clk), .rst(rst), .en(1'b1), .d(state_nxt[0]), .q(state[0]));
    dff u_state1 (.clk(clk), .rst(rst), .en(1'b1), .d(state_nxt[1]), .q(state[1]));

    dmem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (issue),
        .en   (is_wait & ~mem_valid),
        .count(count),
        .tc   (tc)
    );

    // request fields are captured once at issue; MemWrite wins when both bits are set
    dff    u_wr    (.clk(clk), .rst(rst), .en(issue), .d(MemWrite),  .q(mem_wr));
    dff_16 u_addr  (.clk(clk), .rst(rst), .en(issue), .d(Addr),      .q(mem_addr));
    dff_16 u_wdata (.clk(clk), .rst(rst), .en(issue), .d(WriteData), .q(mem_wdata));

    assign rd_load = (finish_ok | abort) & ~mem_wr;
    assign rd_next = finish_ok ? mem_rdata : '0;

    dff_16 u_rdata (.clk(clk), .rst(rst), .en(rd_load), .d(rd_next), .q(ReadData));
    dff    u_err   (.clk(clk), .rst(rst), .en(abort),   .d(1'b1),    .q(Err));

    // the counter is still zero only in the first WAIT cycle
    assign mem_en = is_wait & (count == '0);
    assign Stall  = issue | is_wait;
    assign Done   = is_done;

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Scoreboard bench for mem_stage_access_ctrl with a latency-programmable memory model.
module tb_mem_stage_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [15:0] Addr, WriteData;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid;
    logic        Stall, Done, Err;
    logic [15:0] ReadData;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          stall;
        int          en_cnt;
        int          en_cyc;
        int          en_in_done;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
        logic        done;
    } obs_t;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          stall;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] model_rd  = 16'h0000;
    logic        model_err = 1'b0;

    mem_stage_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .Stall(Stall), .ReadData(ReadData), .Done(Done), .Err(Err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: latency lat (-1 = never) relative to mem_en
    task automatic push_exp(input logic wr, input int lat, input logic [15:0] rdat);
        exp_t e;
        logic to;
        to = !(lat >= 0 && lat < TO);
        if (!wr) model_rd = to ? 16'h0000 : rdat;
        if (to) model_err = 1'b1;
        e.rdata = model_rd;
        e.err   = model_err;
        e.stall = to ? 1 + TO : 2 + lat;
        sbq.push_back(e);
    endtask

    task automatic run_access(input logic rd, input logic wr, input logic [15:0] a,
                              input logic [15:0] wd, input int lat, input logic [15:0] rdat,
                              output obs_t o);
        o = '{default: 0};
        for (int i = 0; i < 64 && !o.done; i++) begin
            @(posedge clk); #1;
            MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd;
            mem_valid = (lat >= 0 && i == 1 + lat);
            mem_rdata = mem_valid ? rdat : 16'hDEAD;
            @(negedge clk);
            if (Stall) o.stall++;
            if (mem_en) begin
                o.en_cnt++; o.en_cyc = cyc; o.wr = mem_wr; o.addr = mem_addr; o.wdata = mem_wdata;
                if (Done) o.en_in_done++;
            end
            if (Done) begin o.done = 1'b1; o.rdata = ReadData; o.err = Err; end
        end
        mem_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        MemRead = 1'b0; MemWrite = 1'b0; Addr = 16'h0; WriteData = 16'h0;
        mem_valid = 1'b0; mem_rdata = 16'h0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; idle_inputs();
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if ({Stall, mem_en, mem_wr, Done, Err} !== 5'b0) begin n_bad++;
            $display("FAIL reset_ctrl got %b want 00000", {Stall, mem_en, mem_wr, Done, Err}); end
        n_vec++; if ({mem_addr, mem_wdata, ReadData} !== 48'h0) begin n_bad++;
            $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, ReadData}); end
        n_vec++; if (dut.state !== 2'b00) begin n_bad++;
            $display("FAIL reset_state got %b want 00", dut.state); end
        @(posedge clk); #1; rst = 1'b0;
        model_rd = 16'h0; model_err = 1'b0;
    endtask

    task automatic test_load0();
        obs_t o; exp_t e;
        push_exp(1'b0, 0, 16'hBEEF);
        run_access(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'hBEEF, o);
        idle_inputs();
        e = sbq.pop_front();
        n_vec++; if (o.done !== 1'b1) begin n_bad++; $display("FAIL load0_done got %b want 1", o.done); end
        n_vec++; if (o.en_cnt != 1) begin n_bad++; $display("FAIL load0_en_cnt got %0d want 1", o.en_cnt); end
        n_vec++; if (o.wr !== 1'b0) begin n_bad++; $display("FAIL load0_wr got %b want 0", o.wr); end
        n_vec++; if (o.addr !== 16'h0040) begin n_bad++; $display("FAIL load0_addr got %h want 0040", o.addr); end
        n_vec++; if (o.stall != e.stall) begin n_bad++; $display("FAIL load0_stall got %0d want %0d", o.stall, e.stall); end
        n_vec++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL load0_rdata got %h want %h", o.rdata, e.rdata); end
    endtask

    task automatic test_store3();
        obs_t o; exp_t e;
        push_exp(1'b1, 3, 16'hFFFF);
        run_access(1'b0, 1'b1, 16'h0100, 16'h1234, 3, 16'hFFFF, o);
        idle_inputs();
        e = sbq.pop_front();
        n_vec++; if (o.wr !== 1'b1) begin n_bad++; $display("FAIL store3_wr got %b want 1", o.wr); end
        n_vec++; if (o.wdata !== 16'h1234) begin n_bad++; $display("FAIL store3_wdata got %h want 1234", o.wdata); end
        n_vec++; if (o.addr !== 16'h0100) begin n_bad++; $display("FAIL store3_addr got %h want 0100", o.addr); end
        n_vec++; if (o.stall != e.stall) begin n_bad++; $display("FAIL store3_stall got %0d want %0d", o.stall, e.stall); end
        n_vec++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL store3_rdata got %h want %h", o.rdata, e.rdata); end
        n_vec++; if (o.err !== e.err) begin n_bad++; $display("FAIL store3_err got %b want %b", o.err, e.err); end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2; exp_t e1, e2;
        push_exp(1'b0, 0, 16'h1111);
        run_access(1'b1, 1'b0, 16'h0080, 16'h0000, 0, 16'h1111, o1);
        push_exp(1'b1, 0, 16'hEEEE);
        run_access(1'b0, 1'b1, 16'h0090, 16'h2222, 0, 16'hEEEE, o2);
        idle_inputs();
        e1 = sbq.pop_front();
        e2 = sbq.pop_front();
        n_vec++; if (o2.en_cyc - o1.en_cyc != 3) begin n_bad++;
            $display("FAIL b2b_gap got %0d want 3", o2.en_cyc - o1.en_cyc); end
        n_vec++; if (o1.en_cnt != 1 || o2.en_cnt != 1) begin n_bad++;
            $display("FAIL b2b_en_cnt got %0d/%0d want 1/1", o1.en_cnt, o2.en_cnt); end
        n_vec++; if (o1.en_in_done + o2.en_in_done != 0) begin n_bad++;
            $display("FAIL b2b_en_in_done got %0d want 0", o1.en_in_done + o2.en_in_done); end
        n_vec++; if (o1.rdata !== e1.rdata) begin n_bad++; $display("FAIL b2b_load_rdata got %h want %h", o1.rdata, e1.rdata); end
        n_vec++; if (o2.rdata !== e2.rdata) begin n_bad++; $display("FAIL b2b_store_rdata got %h want %h", o2.rdata, e2.rdata); end
        n_vec++; if (o2.stall != e2.stall) begin n_bad++; $display("FAIL b2b_stall got %0d want %0d", o2.stall, e2.stall); end
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e;
        push_exp(1'b0, -1, 16'h0000);
        run_access(1'b1, 1'b0, 16'h0200, 16'h0000, -1, 16'h0000, o);
        idle_inputs();
        e = sbq.pop_front();
        n_vec++; if (o.done !== 1'b1) begin n_bad++; $display("FAIL tmo_done got %b want 1", o.done); end
        n_vec++; if (o.stall != e.stall) begin n_bad++; $display("FAIL tmo_stall got %0d want %0d", o.stall, e.stall); end
        n_vec++; if (o.err !== e.err) begin n_bad++; $display("FAIL tmo_err got %b want %b", o.err, e.err); end
        n_vec++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL tmo_rdata got %h want %h", o.rdata, e.rdata); end
        push_exp(1'b0, TO - 1, 16'h7777);
        run_access(1'b1, 1'b0, 16'h0204, 16'h0000, TO - 1, 16'h7777, o);
        idle_inputs();
        e = sbq.pop_front();
        n_vec++; if (o.err !== e.err) begin n_bad++; $display("FAIL tmo_sticky_err got %b want %b", o.err, e.err); end
        n_vec++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL tmo_lastcycle_rdata got %h want %h", o.rdata, e.rdata); end
        n_vec++; if (o.stall != e.stall) begin n_bad++; $display("FAIL tmo_lastcycle_stall got %0d want %0d", o.stall, e.stall); end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        model_rd = 16'h0; model_err = 1'b0;
        @(negedge clk);
        n_vec++; if (Err !== model_err) begin n_bad++; $display("FAIL tmo_err_clear got %b want %b", Err, model_err); end
    endtask

    task automatic test_reset_in_wait();
        @(posedge clk); #1;
        MemRead = 1'b1; Addr = 16'h0300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; MemRead = 1'b0; Addr = 16'h0;
        @(posedge clk); #1;
        rst = 1'b0; mem_valid = 1'b1; mem_rdata = 16'h5555;
        model_rd = 16'h0; model_err = 1'b0;
        @(negedge clk);
        n_vec++; if ({Stall, mem_en, mem_wr, Done, Err} !== 5'b0) begin n_bad++;
            $display("FAIL rstwait_ctrl got %b want 00000", {Stall, mem_en, mem_wr, Done, Err}); end
        n_vec++; if ({mem_addr, mem_wdata, ReadData} !== 48'h0) begin n_bad++;
            $display("FAIL rstwait_data got %h want 0", {mem_addr, mem_wdata, ReadData}); end
        n_vec++; if (dut.state !== 2'b00) begin n_bad++; $display("FAIL rstwait_state got %b want 00", dut.state); end
        @(posedge clk); #1; mem_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (ReadData !== model_rd) begin n_bad++; $display("FAIL rstwait_stray_rdata got %h want %h", ReadData, model_rd); end
        n_vec++; if (Done !== 1'b0) begin n_bad++; $display("FAIL rstwait_done got %b want 0", Done); end
    endtask

    task automatic test_both_and_stray();
        obs_t o; exp_t e;
        push_exp(1'b0, 0, 16'h4242);
        run_access(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'h4242, o);
        idle_inputs();
        void'(sbq.pop_front());
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_rdata = 16'h9999;
        @(negedge clk);
        n_vec++; if ({Stall, mem_en, Done} !== 3'b000) begin n_bad++;
            $display("FAIL stray_ctrl got %b want 000", {Stall, mem_en, Done}); end
        @(posedge clk); #1; mem_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (ReadData !== model_rd) begin n_bad++; $display("FAIL stray_rdata got %h want %h", ReadData, model_rd); end
        n_vec++; if (dut.state !== 2'b00) begin n_bad++; $display("FAIL stray_state got %b want 00", dut.state); end
        push_exp(1'b1, 2, 16'h0F0F);
        run_access(1'b1, 1'b1, 16'h0400, 16'hABCD, 2, 16'h0F0F, o);
        idle_inputs();
        e = sbq.pop_front();
        n_vec++; if (o.wr !== 1'b1) begin n_bad++; $display("FAIL both_wr got %b want 1", o.wr); end
        n_vec++; if (o.wdata !== 16'hABCD) begin n_bad++; $display("FAIL both_wdata got %h want abcd", o.wdata); end
        n_vec++; if (o.stall != e.stall) begin n_bad++; $display("FAIL both_stall got %0d want %0d", o.stall, e.stall); end
        n_vec++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL both_rdata got %h want %h", o.rdata, e.rdata); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load0();
        test_store3();
        test_back_to_back();
        test_timeout();
        test_reset_in_wait();
        test_both_and_stray();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
